// File: rtl/logit_requant.sv
// logit_requant: requantizes final-layer class accumulators to signed 12-bit, buffers one frame and
// replays it as a NUM_CLASS-beat burst followed by an idle gap. Optional macro: LOGIT_ROUND_EN (round half-up).
module logit_requant #(
  parameter int ACC_W     = 24,
  parameter int SHIFT     = 8,
  parameter int NUM_CLASS = 10,
  parameter int GAP_CYC   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    acc_valid,
  input  logic signed [ACC_W-1:0] acc_data,
  output logic                    acc_ready,
  output logic                    valid_out,
  output logic signed [11:0]      data_out,
  output logic                    sat_flag,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int CNT_W = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(NUM_CLASS - 1);
  localparam logic [GAP_W-1:0]   LAST_GAP = GAP_W'(GAP_CYC - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2047);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-2048);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, GAP} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, wr_idx;
  logic [GAP_W-1:0]       gcnt;
  logic signed [11:0]     score_mem [NUM_CLASS];
  logic                   accept;
  logic signed [ACC_W:0]  acc_ext, acc_sum, q_wide;
  logic signed [11:0]     q;
  logic                   clip;

  // Requantize the incoming beat; one extra bit keeps the rounding add from overflowing.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_ext = {acc_data[ACC_W-1], acc_data};
`ifdef LOGIT_ROUND_EN
    acc_sum = acc_ext + ((ACC_W+1)'(1) << (SHIFT - 1));
`else
    acc_sum = acc_ext;
`endif
    q_wide = acc_sum >>> SHIFT;
    q      = q_wide[11:0];
    clip   = 1'b0;
    if (q_wide > SAT_MAX) begin
      q    = 12'h7FF;
      clip = 1'b1;
    end else if (q_wide < SAT_MIN) begin
      q    = 12'h800;
      clip = 1'b1;
    end
  end

  assign accept = acc_valid && acc_ready;
  assign wr_idx = (state == IDLE) ? '0 : cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, COLLECT: if (accept) state_nxt = (wr_idx == LAST_IDX) ? EMIT : COLLECT;
      EMIT:          if (cnt == LAST_IDX) state_nxt = GAP;
      GAP:           if (gcnt == LAST_GAP) state_nxt = IDLE;
      default:       state_nxt = IDLE;
    endcase
  end

  // cnt is the write index while collecting and the replay index while emitting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      gcnt     <= '0;
      sat_flag <= 1'b0;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          if (accept) begin
            cnt      <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
            sat_flag <= (state == IDLE) ? clip : (sat_flag | clip);
          end
        end
        EMIT: begin
          cnt  <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
          gcnt <= '0;
        end
        GAP:     gcnt <= gcnt + 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the score buffer is deliberately not reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if (accept) score_mem[wr_idx] <= q;
  end

  always_comb begin
    acc_ready  = 1'b0;
    valid_out  = 1'b0;
    frame_done = 1'b0;
    data_out   = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE, COLLECT: acc_ready = !rst;
      EMIT: begin
        valid_out  = 1'b1;
        data_out   = score_mem[cnt];
        frame_done = (cnt == LAST_IDX);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_logit_requant.sv
// tb_logit_requant: directed self-checking bench for logit_requant; expected scores are hand-computed
// for SHIFT=8 (rounded values selected when LOGIT_ROUND_EN is defined).
module tb_logit_requant;

  localparam int ACC_W     = 24;
  localparam int SHIFT     = 8;
  localparam int NUM_CLASS = 10;
  localparam int GAP_CYC   = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    acc_valid;
  logic signed [ACC_W-1:0] acc_data;
  logic                    acc_ready, valid_out, sat_flag, frame_done, busy;
  logic signed [11:0]      data_out;

  logit_requant #(.ACC_W(ACC_W), .SHIFT(SHIFT), .NUM_CLASS(NUM_CLASS), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_data(acc_data), .acc_ready(acc_ready),
    .valid_out(valid_out), .data_out(data_out), .sat_flag(sat_flag), .frame_done(frame_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int                 acc_cyc[$];
  int                 out_cyc[$];
  int                 fd_cyc[$];
  logic signed [11:0] out_q[$];
  int                 zero_viol = 0;
  int                 ready_viol = 0;
  int                 n_checks = 0;
  int                 n_pass = 0;

  // Passive monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (acc_valid && acc_ready) acc_cyc.push_back(cyc);
      if (valid_out) begin
        out_q.push_back(data_out);
        out_cyc.push_back(cyc);
        if (acc_ready) ready_viol++;
      end else if (data_out !== 12'sd0) begin
        zero_viol++;
      end
      if (frame_done) fd_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic put(input int v);
    int n = 0;
    acc_valid = 1'b1;
    acc_data  = ACC_W'(v);
    @(negedge clk);
    while (!acc_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("accept_ready", acc_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    acc_valid = 1'b0;
    acc_data  = '0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Checks and consumes one recorded frame: 10 accepts, 10 burst beats, 1 frame_done.
  task automatic check_frame(input string tag, input int exp[NUM_CLASS], input logic exp_sat);
    int holes = 0;
    check({tag, "_have_beats"}, out_q.size() >= NUM_CLASS, 1);
    check({tag, "_have_accepts"}, acc_cyc.size() >= NUM_CLASS, 1);
    check({tag, "_have_done"}, fd_cyc.size() >= 1, 1);
    if (out_q.size() < NUM_CLASS || acc_cyc.size() < NUM_CLASS || fd_cyc.size() < 1) return;
    check({tag, "_latency"}, out_cyc[0], acc_cyc[NUM_CLASS-1] + 1);
    for (int i = 0; i < NUM_CLASS; i++) if (out_cyc[i] != out_cyc[0] + i) holes++;
    check({tag, "_contiguous"}, holes, 0);
    check({tag, "_frame_done"}, fd_cyc[0], out_cyc[NUM_CLASS-1]);
    for (int i = 0; i < NUM_CLASS; i++) check($sformatf("%s_data%0d", tag, i), out_q[i], exp[i]);
    check({tag, "_sat"}, sat_flag, exp_sat);
    for (int i = 0; i < NUM_CLASS; i++) begin
      void'(out_q.pop_front());
      void'(out_cyc.pop_front());
      void'(acc_cyc.pop_front());
    end
    void'(fd_cyc.pop_front());
  endtask

  initial begin
    int e[NUM_CLASS];
    int r[NUM_CLASS];

    // Reset state
    rst = 1'b1;
    acc_valid = 1'b0;
    acc_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", acc_ready, 0);
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_done", frame_done, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", acc_ready, 1);

    // Basic frame: k*256 -> k
    for (int k = 0; k < NUM_CLASS; k++) put(k * 256);
    idle_in();
    wait_cycles(15);
    e = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    check_frame("basic", e, 1'b0);

    // Saturation at indices 2 and 7
    for (int k = 0; k < NUM_CLASS; k++) put(k == 2 ? 1048576 : (k == 7 ? -1048576 : k * 256));
    idle_in();
    wait_cycles(15);
    e = '{0, 1, 2047, 3, 4, 5, 6, -2048, 8, 9};
    check_frame("sat", e, 1'b1);
    wait_cycles(10);
    check("sat_hold_idle", sat_flag, 1);

    // Rounding and saturation boundaries; this clean frame also clears sat_flag
    r = '{384, -384, 0, 255, -1, 256, 128, -129, 524032, -524288};
    for (int k = 0; k < NUM_CLASS; k++) put(r[k]);
    idle_in();
    wait_cycles(15);
`ifdef LOGIT_ROUND_EN
    e = '{2, -1, 0, 1, 0, 1, 1, -1, 2047, -2048};
`else
    e = '{1, -2, 0, 0, -1, 1, 0, -1, 2047, -2048};
`endif
    check_frame("round", e, 1'b0);

    // Backpressure: 20 beats with acc_valid held high throughout
    for (int i = 1; i <= 20; i++) put(i * 256);
    idle_in();
    wait_cycles(15);
    check("bp_beat11_gap",
          (acc_cyc.size() > NUM_CLASS && fd_cyc.size() > 0) ? acc_cyc[NUM_CLASS] - fd_cyc[0] : -1,
          GAP_CYC + 1);
    e = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    check_frame("bp1", e, 1'b0);
    e = '{11, 12, 13, 14, 15, 16, 17, 18, 19, 20};
    check_frame("bp2", e, 1'b0);

    // Sparse input: one beat every 3 cycles
    for (int k = 0; k < NUM_CLASS; k++) begin
      put((9 - k) * 256);
      idle_in();
      wait_cycles(2);
    end
    wait_cycles(15);
    e = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    check_frame("sparse", e, 1'b0);

    // Reset after 5 accepted beats, then a fresh frame
    for (int k = 0; k < 5; k++) put((100 + k) * 256);
    idle_in();
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    acc_cyc.delete();
    wait_cycles(3);
    check("rst_mid_no_burst", out_q.size(), 0);
    for (int k = 0; k < NUM_CLASS; k++) put(-(k + 1) * 256);
    idle_in();
    wait_cycles(15);
    check("rst_mid_burst_len", out_q.size(), NUM_CLASS);
    e = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
    check_frame("rst_mid", e, 1'b0);

    // Global invariants
    check("data_zero_when_idle", zero_viol, 0);
    check("ready_low_in_burst", ready_viol, 0);
    check("no_stray_beats", out_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
